// File: rtl/pow2n_pipeline_hs_pkg.sv
// Shared widths and helpers for the x^(2^STAGES) squaring pipeline.
// Used by both builds; the POW_PIPE_SAT_EN build also uses SAT_ONES.
package pow_pipe_pkg;

  localparam int DEF_IN_W   = 7;
  localparam int DEF_STAGES = 3;
  localparam int DEF_OUT_W  = 64;

  // Wide enough for any practical OUT_W; sliced down to OUT_W at the output.
  localparam int SAT_MAX_W = 1024;
  localparam logic [SAT_MAX_W-1:0] SAT_ONES = '1;

  // Register width of stage k: min(in_w << k, out_w).
  function automatic int stage_w(input int in_w, input int k, input int out_w);
    longint shifted;
    shifted = longint'(in_w) << k;
    return (shifted > longint'(out_w)) ? out_w : int'(shifted);
  endfunction

  // Bit offset of stage k's register inside the packed inter-stage bus.
  function automatic int stage_off(input int in_w, input int k, input int out_w);
    int acc;
    acc = 0;
    for (int j = 0; j < k; j++) begin
      acc += stage_w(in_w, j + 1, out_w);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pow2n_pipeline_hs_stage.sv
// One squaring register with valid, optional sticky overflow and load logic.
// Overflow tracking exists only when POW_PIPE_SAT_EN is defined.
module pow_sq_stage
  import pow_pipe_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = 2 * DEF_IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_i,
  input  logic             valid_i,
`ifdef POW_PIPE_SAT_EN
  input  logic             ovf_i,
  output logic             ovf_o,
`endif
  input  logic             nxt_load_i,
  output logic             load_o,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o
);

  logic [OUT_W-1:0] data_q;
  logic [OUT_W-1:0] data_d;
  logic             valid_q;

  // Bubble-collapsing: an empty stage always loads, a full one only if it drains.
  assign load_o = !valid_q || nxt_load_i;

`ifdef POW_PIPE_SAT_EN
  localparam int PW = 2 * IN_W;
  logic [PW-1:0] op_ext;
  logic [PW-1:0] prod;
  logic          hi_lost;
  logic          ovf_q;
  logic          ovf_d;

  assign op_ext = PW'(data_i);
  assign prod   = op_ext * op_ext;
  assign data_d = prod[OUT_W-1:0];

  if (PW > OUT_W) begin : g_hi
    assign hi_lost = |prod[PW-1:OUT_W];
  end else begin : g_nohi
    assign hi_lost = 1'b0;
  end

  assign ovf_d = ovf_i | hi_lost;
  assign ovf_o = ovf_q;
`else
  logic [OUT_W-1:0] op_ext;
  assign op_ext = OUT_W'(data_i);
  assign data_d = op_ext * op_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef POW_PIPE_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else if (load_o) begin
      data_q  <= data_d;
      valid_q <= valid_i;
`ifdef POW_PIPE_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pow2n_pipeline_hs.sv
// Valid/ready pipeline computing x^(2^STAGES) by repeated squaring.
// Define POW_PIPE_SAT_EN to saturate overflowed results to all-ones with o_ovf.
module pow2n_pipeline_hs
  import pow_pipe_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int STAGES = DEF_STAGES,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int TOT_W    = stage_off(IN_W, STAGES, OUT_W);
  localparam int LAST_W   = stage_w(IN_W, STAGES, OUT_W);
  localparam int LAST_OFF = stage_off(IN_W, STAGES - 1, OUT_W);

  // All stage registers packed back to back; stage k sits at stage_off(k).
  logic [TOT_W-1:0]  data_bus;
  logic [STAGES:0]   load_chain;
  logic [STAGES-1:0] valid_vec;
`ifdef POW_PIPE_SAT_EN
  logic [STAGES-1:0] ovf_vec;
`endif

  assign load_chain[STAGES] = o_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_st
      localparam int WI  = stage_w(IN_W, gi, OUT_W);
      localparam int WO  = stage_w(IN_W, gi + 1, OUT_W);
      localparam int OFF = stage_off(IN_W, gi, OUT_W);

      logic [WI-1:0] src_data;
      logic          src_valid;
`ifdef POW_PIPE_SAT_EN
      logic          src_ovf;
`endif

      if (gi == 0) begin : g_head
        assign src_data  = i_data;
        assign src_valid = i_valid;
`ifdef POW_PIPE_SAT_EN
        assign src_ovf   = 1'b0;
`endif
      end else begin : g_link
        localparam int PREV_OFF = stage_off(IN_W, gi - 1, OUT_W);
        assign src_data  = data_bus[PREV_OFF +: WI];
        assign src_valid = valid_vec[gi-1];
`ifdef POW_PIPE_SAT_EN
        assign src_ovf   = ovf_vec[gi-1];
`endif
      end

      pow_sq_stage #(
        .IN_W (WI),
        .OUT_W(WO)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .data_i    (src_data),
        .valid_i   (src_valid),
`ifdef POW_PIPE_SAT_EN
        .ovf_i     (src_ovf),
        .ovf_o     (ovf_vec[gi]),
`endif
        .nxt_load_i(load_chain[gi+1]),
        .load_o    (load_chain[gi]),
        .data_o    (data_bus[OFF +: WO]),
        .valid_o   (valid_vec[gi])
      );
    end
  endgenerate

  assign i_ready = load_chain[0];
  assign o_valid = valid_vec[STAGES-1];
  assign o_busy  = |valid_vec;

  logic [OUT_W-1:0] last_ext;
  assign last_ext = OUT_W'(data_bus[LAST_OFF +: LAST_W]);

`ifdef POW_PIPE_SAT_EN
  assign o_ovf  = ovf_vec[STAGES-1];
  assign o_data = o_ovf ? SAT_ONES[OUT_W-1:0] : last_ext;
`else
  assign o_ovf  = 1'b0;
  assign o_data = last_ext;
`endif

endmodule

// File: tb/tb_pow2n_pipeline_hs.sv
// Directed bench for pow2n_pipeline_hs: default 64-bit instance plus a 32-bit
// instance for the overflow/saturation cases (POW_PIPE_SAT_EN aware).
module tb_pow2n_pipeline_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]  i_data;
  logic        i_valid, i_ready, o_valid, o_ready, o_ovf, o_busy;
  logic [63:0] o_data;

  logic [6:0]  u_i_data;
  logic        u_i_valid, u_i_ready, u_o_valid, u_o_ready, u_o_ovf, u_o_busy;
  logic [31:0] u_o_data;

  pow2n_pipeline_hs #(.IN_W(7), .STAGES(3), .OUT_W(64)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  pow2n_pipeline_hs #(.IN_W(7), .STAGES(3), .OUT_W(32)) dut32 (
    .clk(clk), .rst(rst), .i_data(u_i_data), .i_valid(u_i_valid), .i_ready(u_i_ready),
    .o_data(u_o_data), .o_valid(u_o_valid), .o_ready(u_o_ready), .o_ovf(u_o_ovf), .o_busy(u_o_busy)
  );

  typedef struct {
    longint unsigned val;
    int              acc;
    bit              seen;
  } item_t;

  item_t exp_q[$];
  int    vec_cnt  = 0;
  int    miss_cnt = 0;
  int    cyc      = 0;
  int    rx_cnt   = 0;
  bit    lat_chk  = 1'b0;
  bit    last_acc = 1'b0;

  function automatic longint unsigned pow8(input longint unsigned x);
    longint unsigned y;
    y = x * x;
    y = y * y;
    return y * y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: record accept/consume before the edge, check outputs after it.
  task automatic step();
    bit          acc, pop, stall;
    logic [63:0] prev;
    item_t       it;
    #1;
    acc   = i_valid && i_ready;
    pop   = o_valid && o_ready;
    stall = o_valid && !o_ready;
    prev  = o_data;
    it.val  = pow8(64'(i_data));
    it.acc  = cyc;
    it.seen = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (pop) begin
      $display("out[%0d] = %0d", rx_cnt, prev);
      rx_cnt++;
      if (exp_q.size() > 0) exp_q.delete(0);
    end
    if (acc) exp_q.push_back(it);
    last_acc = acc;
    if (stall) begin
      chk("stall_data", o_data, prev);
      chk("stall_valid", 64'(o_valid), 64'd1);
    end
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(o_valid), 64'd0);
      end else begin
        chk("data", o_data, exp_q[0].val);
        chk("ovf", 64'(o_ovf), 64'd0);
        if (lat_chk && !exp_q[0].seen) chk("latency", 64'(cyc - exp_q[0].acc), 64'd3);
        exp_q[0].seen = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() > 0; n++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int rx0;
    i_valid   = 1'b0;
    i_data    = '0;
    o_ready   = 1'b1;
    u_i_valid = 1'b0;
    u_i_data  = '0;
    u_o_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(i_ready), 64'd1);

    // Full-rate stream 0..99.
    lat_chk = 1'b1;
    rx0 = rx_cnt;
    for (int i = 0; i < 100; i++) begin
      i_valid = 1'b1;
      i_data  = 7'(i);
      step();
    end
    i_valid = 1'b0;
    drain(20);
    chk("stream_rx", 64'(rx_cnt - rx0), 64'd100);

    // Largest operand.
    i_valid = 1'b1;
    i_data  = 7'd127;
    step();
    i_valid = 1'b0;
    step();
    step();
    chk("pow127_valid", 64'(o_valid), 64'd1);
    chk("pow127", o_data, 64'd67675234241018881);
    chk("pow127_ovf", 64'(o_ovf), 64'd0);
    drain(10);

    // o_ready toggling every 2 cycles.
    lat_chk = 1'b0;
    rx0 = rx_cnt;
    k = 0;
    for (int t = 0; t < 80 && (k < 10 || exp_q.size() > 0); t++) begin
      o_ready = ((t / 2) % 2) == 0;
      i_valid = (k < 10);
      i_data  = 7'(k + 3);
      step();
      if (last_acc) k++;
    end
    o_ready = 1'b1;
    i_valid = 1'b0;
    chk("toggle_accepted", 64'(k), 64'd10);
    chk("toggle_rx", 64'(rx_cnt - rx0), 64'd10);
    chk("toggle_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 4 offered with o_ready low.
    rx0 = rx_cnt;
    o_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 6; t++) begin
      i_valid = 1'b1;
      i_data  = 7'(40 + k);
      step();
      if (last_acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd3);
    chk("bp_ready", 64'(i_ready), 64'd0);
    chk("bp_busy", 64'(o_busy), 64'd1);
    o_ready = 1'b1;
    for (int t = 0; t < 20 && (k < 4 || exp_q.size() > 0); t++) begin
      i_valid = (k < 4);
      i_data  = 7'(40 + k);
      step();
      if (last_acc) k++;
    end
    i_valid = 1'b0;
    chk("bp_total", 64'(k), 64'd4);
    chk("bp_rx", 64'(rx_cnt - rx0), 64'd4);
    chk("bp_empty", 64'(exp_q.size()), 64'd0);

    // 32-bit result width: 16^8 = 2^32 overflows, 15^8 fits.
    chk("u_ready", 64'(u_i_ready), 64'd1);
    u_i_valid = 1'b1;
    u_i_data  = 7'd16;
    step();
    u_i_data  = 7'd15;
    step();
    u_i_valid = 1'b0;
    step();
    chk("u16_valid", 64'(u_o_valid), 64'd1);
`ifdef POW_PIPE_SAT_EN
    chk("u16_data", 64'(u_o_data), 64'hFFFFFFFF);
    chk("u16_ovf", 64'(u_o_ovf), 64'd1);
`else
    chk("u16_data", 64'(u_o_data), 64'd0);
    chk("u16_ovf", 64'(u_o_ovf), 64'd0);
`endif
    $display("u32 out = %0d ovf=%0b", u_o_data, u_o_ovf);
    step();
    chk("u15_valid", 64'(u_o_valid), 64'd1);
    chk("u15_data", 64'(u_o_data), 64'd2562890625);
    chk("u15_ovf", 64'(u_o_ovf), 64'd0);
    $display("u32 out = %0d ovf=%0b", u_o_data, u_o_ovf);
    step();
    chk("u_idle_busy", 64'(u_o_busy), 64'd0);

    // Reset pulse with two operands in flight.
    rx0 = rx_cnt;
    i_valid = 1'b1;
    i_data  = 7'd5;
    step();
    i_data  = 7'd6;
    step();
    i_valid = 1'b0;
    chk("inflight_busy", 64'(o_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_data", o_data, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    #1;
    chk("ready_after_pulse", 64'(i_ready), 64'd1);
    for (int t = 0; t < 6; t++) begin
      step();
      chk("no_ghost", 64'(o_valid), 64'd0);
    end
    lat_chk = 1'b1;
    i_valid = 1'b1;
    i_data  = 7'd9;
    step();
    i_valid = 1'b0;
    drain(10);
    chk("post_rst_rx", 64'(rx_cnt - rx0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/pow2n_pipeline_hs.md
POW2N_PIPELINE_HS -- requirements
Module: pow2n_pipeline_hs

Interface
REQ-001 SHALL have parameter IN_W, default 7: unsigned input operand width.
REQ-002 SHALL have parameter STAGES, default 3: number of squaring stages; exponent = 2^STAGES.
REQ-003 SHALL have parameter OUT_W, default 64: result width; legal range IN_W..IN_W<<STAGES.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port i_data, input, IN_W: operand x.
REQ-007 SHALL have port i_valid, input, 1: operand offered.
REQ-008 SHALL have port i_ready, output, 1: operand accepted when i_valid && i_ready.
REQ-009 SHALL have port o_data, output, OUT_W: x^(2^STAGES).
REQ-010 SHALL have port o_valid, output, 1: result offered.
REQ-011 SHALL have port o_ready, input, 1: result consumed when o_valid && o_ready.
REQ-012 SHALL have port o_ovf, output, 1: the true result exceeded OUT_W bits.
REQ-013 SHALL have port o_busy, output, 1: at least one stage holds valid data.

Function
REQ-014 Stage k (1..STAGES) SHALL register the square of stage k-1 data; stage 0 data is i_data.
REQ-015 Stage k register width SHALL be min(IN_W<<k, OUT_W); squaring is unsigned, keeping the low bits.
REQ-016 Latency SHALL be exactly STAGES cycles from acceptance to o_valid while o_ready stays high.
REQ-017 Throughput SHALL be one result per cycle with o_ready held high.
REQ-018 Each stage SHALL load when its valid is low or the next stage is loading (bubble-collapsing ready chain); i_ready is stage 1's load condition.
REQ-019 A stalled stage SHALL hold its data, valid and ovf bits unchanged.
REQ-020 o_data/o_valid/o_ovf SHALL stay stable while o_valid && !o_ready.
REQ-021 Overflow SHALL be tracked as a sticky per-stage bit, set when any discarded high bit of a square is nonzero, and propagated with the data.
REQ-022 A transfer on both the input and the output in the same cycle SHALL move both, with no loss or duplication.
REQ-023 i_ready SHALL be combinational from o_ready and the stage valids; no combinational path from i_data to any output.
REQ-024 o_busy SHALL be the OR of all stage valids.

Reset
REQ-025 While rst is high, all stage valids, o_valid, o_ovf and o_busy SHALL be 0.
REQ-026 While rst is high, o_data and all stage data SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard every in-flight operand; no result is emitted for it after release.
REQ-028 i_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro POW_PIPE_SAT_EN defined: a result with ovf set SHALL drive o_data to all-ones and o_ovf=1.
REQ-030 Macro POW_PIPE_SAT_EN undefined: o_data SHALL be the truncated low OUT_W bits, and o_ovf SHALL be tied 0 with no overflow logic.

Structure
REQ-031 Package pow_pipe_pkg SHALL hold default widths, the stage-width function min(IN_W<<k, OUT_W) and the all-ones saturation constant.
REQ-032 A single sub-module, pow_sq_stage (one squaring register with valid, ovf and load logic), SHALL be instantiated STAGES times by a generate loop.

Verification
REQ-033 Defaults, o_ready=1, stream i_data=0..99 one per cycle: o_data = i^8 in order (2->256, 3->6561, 99->9227446944279201), each appearing 3 cycles after acceptance.
REQ-034 Defaults, i_data=127: o_data=67675234241018881 and o_ovf=0.
REQ-035 Stream 10 operands with o_ready toggling 1/0 every 2 cycles: all 10 results arrive in order with no duplicates, and outputs stay stable while stalled.
REQ-036 o_ready=0 with 4 operands offered: 3 are accepted, then i_ready=0 and o_busy=1; after o_ready=1 all 4 results drain.
REQ-037 OUT_W=32, i_data=16: with POW_PIPE_SAT_EN, o_data=0xFFFFFFFF and o_ovf=1; without it, o_data=0 and o_ovf=0; i_data=15 gives 2562890625 with no overflow.
REQ-038 Pulse rst for 1 cycle with 2 operands in flight: o_valid=0 and o_busy=0 immediately; no result appears for either operand; the next operand after release is processed normally.
